// File: rtl/ascon_block_sequencer.sv
// ascon_block_sequencer: control FSM for the ASCON-128 datapath.
// Sequences init, AD, PT and finalization phases and their strobes.
module ascon_block_sequencer #(
   parameter int NB_AD = 1,
   parameter int NB_PT = 4
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       data_valid_i,
   output logic       data_req_o,
   output logic       init_state_o,
   output logic       perm_en_o,
   output logic [3:0] round_o,
   output logic [2:0] block_o,
   output logic       xor_data_o,
   output logic       xor_key_begin_o,
   output logic       xor_key_end_o,
   output logic       domain_sep_o,
   output logic       cipher_valid_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_AD_WAIT,
      S_AD_PERM,
      S_PT_WAIT,
      S_PT_PERM,
      S_FINAL,
      S_DONE
   } state_t;

   localparam logic [2:0] AD_LAST = 3'((NB_AD > 0) ? NB_AD - 1 : 0);
   localparam logic [2:0] PT_LAST = 3'(NB_PT - 1);
   localparam logic [3:0] R_LAST  = 4'd11;
   localparam logic [3:0] R_PB    = 4'd6;

   state_t     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [2:0] block_q, block_d;

   always_comb begin
      state_d         = state_q;
      round_d         = round_q;
      block_d         = block_q;
      data_req_o      = 1'b0;
      init_state_o    = 1'b0;
      perm_en_o       = 1'b0;
      xor_data_o      = 1'b0;
      xor_key_begin_o = 1'b0;
      xor_key_end_o   = 1'b0;
      domain_sep_o    = 1'b0;
      cipher_valid_o  = 1'b0;
      done_o          = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // gated so no strobe escapes while reset is held
            init_state_o = start_i & resetb_i;
            if (start_i) begin
               state_d = S_INIT;
               round_d = '0;
               block_d = '0;
            end
         end
         S_INIT: begin
            perm_en_o = 1'b1;
            round_d   = round_q + 4'd1;
            if (round_q == R_LAST) begin
               xor_key_end_o = 1'b1;
               round_d       = '0;
               if (NB_AD == 0) begin
                  domain_sep_o = 1'b1;
                  state_d      = S_PT_WAIT;
               end else begin
                  state_d = S_AD_WAIT;
               end
            end
         end
         S_AD_WAIT: begin
            data_req_o = 1'b1;
            if (data_valid_i) begin
               xor_data_o = 1'b1;
               round_d    = R_PB;
               state_d    = S_AD_PERM;
            end
         end
         S_AD_PERM: begin
            perm_en_o = 1'b1;
            round_d   = round_q + 4'd1;
            if (round_q == R_LAST) begin
               round_d = '0;
               if (block_q == AD_LAST) begin
                  domain_sep_o = 1'b1;
                  block_d      = '0;
                  state_d      = S_PT_WAIT;
               end else begin
                  block_d = block_q + 3'd1;
                  state_d = S_AD_WAIT;
               end
            end
         end
         S_PT_WAIT: begin
            data_req_o = 1'b1;
            if (data_valid_i) begin
               xor_data_o     = 1'b1;
               cipher_valid_o = 1'b1;
               if (block_q == PT_LAST) begin
                  xor_key_begin_o = 1'b1;
                  round_d         = '0;
                  state_d         = S_FINAL;
               end else begin
                  round_d = R_PB;
                  state_d = S_PT_PERM;
               end
            end
         end
         S_PT_PERM: begin
            perm_en_o = 1'b1;
            round_d   = round_q + 4'd1;
            if (round_q == R_LAST) begin
               round_d = '0;
               block_d = block_q + 3'd1;
               state_d = S_PT_WAIT;
            end
         end
         S_FINAL: begin
            perm_en_o = 1'b1;
            round_d   = round_q + 4'd1;
            if (round_q == R_LAST) begin
               xor_key_end_o = 1'b1;
               round_d       = '0;
               state_d       = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            round_d = '0;
            block_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            round_d = '0;
            block_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= S_IDLE;
         round_q <= '0;
         block_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         block_q <= block_d;
      end
   end

   assign round_o = round_q;
   assign block_o = block_q;
   assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// tb_ascon_block_sequencer: drives three parameterisations against an
// expected per-cycle trace built from the phase schedule.
module tb_ascon_block_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetb;
   logic [2:0] start, vld;
   logic [2:0] req, init, perm, xd, kb, ke, ds, cv, busy, done;
   logic [3:0] rnd [3];
   logic [2:0] blk [3];

   ascon_block_sequencer u0 (
      .clock_i(clk), .resetb_i(resetb),
      .start_i(start[0]), .data_valid_i(vld[0]),
      .data_req_o(req[0]), .init_state_o(init[0]),
      .perm_en_o(perm[0]), .round_o(rnd[0]),
      .block_o(blk[0]), .xor_data_o(xd[0]),
      .xor_key_begin_o(kb[0]), .xor_key_end_o(ke[0]),
      .domain_sep_o(ds[0]), .cipher_valid_o(cv[0]),
      .busy_o(busy[0]), .done_o(done[0])
   );

   ascon_block_sequencer #(.NB_AD(0), .NB_PT(1)) u1 (
      .clock_i(clk), .resetb_i(resetb),
      .start_i(start[1]), .data_valid_i(vld[1]),
      .data_req_o(req[1]), .init_state_o(init[1]),
      .perm_en_o(perm[1]), .round_o(rnd[1]),
      .block_o(blk[1]), .xor_data_o(xd[1]),
      .xor_key_begin_o(kb[1]), .xor_key_end_o(ke[1]),
      .domain_sep_o(ds[1]), .cipher_valid_o(cv[1]),
      .busy_o(busy[1]), .done_o(done[1])
   );

   ascon_block_sequencer #(.NB_AD(8), .NB_PT(8)) u2 (
      .clock_i(clk), .resetb_i(resetb),
      .start_i(start[2]), .data_valid_i(vld[2]),
      .data_req_o(req[2]), .init_state_o(init[2]),
      .perm_en_o(perm[2]), .round_o(rnd[2]),
      .block_o(blk[2]), .xor_data_o(xd[2]),
      .xor_key_begin_o(kb[2]), .xor_key_end_o(ke[2]),
      .domain_sep_o(ds[2]), .cipher_valid_o(cv[2]),
      .busy_o(busy[2]), .done_o(done[2])
   );

   // flags: {req, init, perm, xd, kb, ke, ds, cv, busy, done}
   typedef struct {
      logic [9:0] f;
      logic [3:0] r;
      logic       cr;
      logic [2:0] b;
      logic       cb;
      logic       v;
      logic       s;
   } step_t;

   step_t tl[$];
   int ncmp = 0;
   int nfail = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] fl(bit rq, bit in, bit pe, bit x,
                                     bit b1, bit k2, bit d, bit c,
                                     bit bz, bit dn);
      return {rq, in, pe, x, b1, k2, d, c, bz, dn};
   endfunction

   function automatic logic [9:0] flags(int d);
      return {req[d], init[d], perm[d], xd[d], kb[d],
              ke[d], ds[d], cv[d], busy[d], done[d]};
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(logic [9:0] f, int r, bit cr, int b, bit cb,
                       bit v, bit s);
      step_t st;
      st.f = f; st.r = 4'(r); st.cr = cr;
      st.b = 3'(b); st.cb = cb; st.v = v; st.s = s;
      tl.push_back(st);
   endtask

   task automatic idle_step();
      push(10'b0, 0, 1, 0, 1, rb(), 1'b0);
   endtask

   // stall cycles then the accepting cycle of one wait state
   task automatic waits(int n, int b, bit pt, bit last);
      for (int i = 0; i < n; i++)
         push(fl(1,0,0,0,0,0,0,0,1,0), 0, 0, b, 1, 1'b0, rb());
      push(fl(1,0,0,1,pt&last,0,0,pt,1,0), 0, 0, b, 1, 1'b1, rb());
   endtask

   task automatic build(int nad, int npt, int pt0, bit rs, bit hold,
                        output int exp_done);
      int stalls = 0;
      int n;
      push(fl(0,1,0,0,0,0,0,0,0,0), 0, 1, 0, 1, rb(), 1'b1);
      for (int r = 0; r < 12; r++)
         push(fl(0,0,1,0,0,r==11,(r==11)&&(nad==0),0,1,0),
              r, 1, 0, 0, rb(), rb());
      for (int a = 0; a < nad; a++) begin
         n = rs ? int'($urandom_range(0, 2)) : 0;
         stalls += n;
         waits(n, a, 0, 0);
         for (int r = 6; r < 12; r++)
            push(fl(0,0,1,0,0,0,(r==11)&&(a==nad-1),0,1,0),
                 r, 1, a, 1, rb(), rb());
      end
      for (int p = 0; p < npt; p++) begin
         if (p == 0 && pt0 >= 0) n = pt0;
         else n = rs ? int'($urandom_range(0, 2)) : 0;
         stalls += n;
         waits(n, p, 1, p == npt - 1);
         if (p != npt - 1)
            for (int r = 6; r < 12; r++)
               push(fl(0,0,1,0,0,0,0,0,1,0), r, 1, p, 1, rb(), rb());
      end
      for (int r = 0; r < 12; r++)
         push(fl(0,0,1,0,0,r==11,0,0,1,0), r, 1, npt-1, 1, rb(), rb());
      push(fl(0,0,0,0,0,0,0,0,1,1), 0, 0, npt-1, 1, rb(), hold);
      exp_done = 19 + 7 * (nad + npt) + stalls;
   endtask

   task automatic exec(int d, int nsteps, output int done_at);
      int n;
      logic [9:0] f;
      step_t st;
      done_at = -1;
      n = tl.size();
      if (nsteps >= 0 && nsteps < n) n = nsteps;
      for (int i = 0; i < n; i++) begin
         st = tl[i];
         @(posedge clk);
         #1;
         start[d] = st.s;
         vld[d]   = st.v;
         @(negedge clk);
         f = flags(d);
         chk($sformatf("d%0d_c%0d_flags", d, i), 32'(f), 32'(st.f));
         if (st.cr)
            chk($sformatf("d%0d_c%0d_round", d, i),
                32'(rnd[d]), 32'(st.r));
         if (st.cb)
            chk($sformatf("d%0d_c%0d_block", d, i),
                32'(blk[d]), 32'(st.b));
         if (f[0] && done_at < 0) done_at = i;
      end
      tl.delete();
      start[d] = 1'b0;
      vld[d]   = 1'b0;
   endtask

   task automatic all_zero(string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_d%0d_flags", tag, d), 32'(flags(d)), 32'd0);
         chk($sformatf("%s_d%0d_round", tag, d), 32'(rnd[d]), 32'd0);
         chk($sformatf("%s_d%0d_block", tag, d), 32'(blk[d]), 32'd0);
      end
   endtask

   int ed, ed2, da;

   initial begin
      resetb = 1'b0;
      start  = 3'b001;
      vld    = 3'b111;
      #1;
      all_zero("reset");
      start = 3'b000;
      vld   = 3'b000;
      @(posedge clk);
      @(posedge clk);
      #1 resetb = 1'b1;
      @(negedge clk);
      all_zero("idle");

      build(1, 4, 0, 1'b0, 1'b0, ed);
      idle_step();
      exec(0, -1, da);
      chk("default_done", 32'(da), 32'd54);

      build(1, 4, 3, 1'b0, 1'b0, ed);
      idle_step();
      exec(0, -1, da);
      chk("backpressure_done", 32'(da), 32'd57);

      repeat (3) begin
         build(1, 4, -1, 1'b1, 1'b0, ed);
         idle_step();
         exec(0, -1, da);
         chk("rand_default_done", 32'(da), 32'(ed));
      end

      build(0, 1, 0, 1'b0, 1'b0, ed);
      idle_step();
      exec(1, -1, da);
      chk("ad0_done", 32'(da), 32'd26);
      repeat (2) begin
         build(0, 1, -1, 1'b1, 1'b0, ed);
         idle_step();
         exec(1, -1, da);
         chk("rand_ad0_done", 32'(da), 32'(ed));
      end

      // abort during FINAL at cycle 45
      build(1, 4, 0, 1'b0, 1'b0, ed);
      exec(0, 46, da);
      chk("abort_no_done", 32'(da), 32'hffff_ffff);
      #1 resetb = 1'b0;
      start[0] = 1'b1;
      #1;
      all_zero("abort");
      @(posedge clk);
      #1;
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_done", 32'(done[0]), 32'd0);
      start[0] = 1'b0;
      resetb = 1'b1;
      repeat (2) idle_step();
      exec(0, -1, da);
      chk("post_abort_idle_done", 32'(da), 32'hffff_ffff);
      build(1, 4, 0, 1'b0, 1'b0, ed);
      idle_step();
      exec(0, -1, da);
      chk("restart_done", 32'(da), 32'd54);

      // back-to-back at the limits with start held through DONE
      build(8, 8, 0, 1'b0, 1'b1, ed);
      chk("limit_trace_len", 32'(tl.size()), 32'd132);
      build(8, 8, 0, 1'b0, 1'b0, ed2);
      idle_step();
      exec(2, -1, da);
      chk("limit_done", 32'(da), 32'd131);

      build(8, 8, -1, 1'b1, 1'b0, ed);
      idle_step();
      exec(2, -1, da);
      chk("rand_limit_done", 32'(da), 32'(ed));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/ascon_block_sequencer.md
# ascon_block_sequencer

Control FSM for the ASCON-128 datapath. It drives the permutation round index and the data block index, and controls the state-load, key-XOR, domain-separation and data-XOR strobes. It takes 64-bit data blocks from upstream through a request/valid handshake. It owns the block-index counter and produces `block_o` itself; this is the driver side of the block-count interface. A per-message `done_o` pulse marks the tag as ready.

## Interface
Parameters:
- `NB_AD`, default 1: number of associated-data blocks per message. Legal range 0..8.
- `NB_PT`, default 4: number of plaintext blocks per message. Legal range 1..8.

Ports:
- `clock_i`, in, 1: clock, rising edge.
- `resetb_i`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: start a message. Sampled only in IDLE.
- `data_valid_i`, in, 1: upstream block available on the datapath input.
- `data_req_o`, out, 1: sequencer is waiting for a block.
- `init_state_o`, out, 1: load IV‖K‖N into the state register.
- `perm_en_o`, out, 1: the permutation executes one round this cycle.
- `round_o`, out, 4: round-constant index, 0..11.
- `block_o`, out, 3: index of the current block within the phase.
- `xor_data_o`, out, 1: XOR the input block into the rate.
- `xor_key_begin_o`, out, 1: XOR 0‖K into the state before finalization.
- `xor_key_end_o`, out, 1: XOR the key into the state after the permutation's last round.
- `domain_sep_o`, out, 1: XOR the domain-separation bit (0…01) into the state.
- `cipher_valid_o`, out, 1: ciphertext block valid on the datapath output.
- `busy_o`, out, 1: high in every state except IDLE.
- `done_o`, out, 1: one-cycle pulse; tag valid.

## Operation
- States: IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL, DONE.
- All strobes are Moore/Mealy combinational decodes of the state plus `data_valid_i`. The datapath acts on them at the same rising edge.
- **IDLE**
  - When `start_i`=1: `init_state_o`=1, go to INIT with round=0 and block=0.
  - `start_i` is ignored in all other states.
- **INIT**
  - `perm_en_o`=1; `round_o` steps 0..11, one step per cycle.
  - At round 11: `xor_key_end_o`=1.
  - If NB_AD>0, go to AD_WAIT. If NB_AD=0, also assert `domain_sep_o`=1 and go to PT_WAIT.
- **AD_WAIT**
  - `data_req_o`=1.
  - When `data_valid_i`=1 (block accepted): `xor_data_o`=1, go to AD_PERM with round=6.
  - While `data_valid_i`=0: stay; all strobes low except `data_req_o`.
- **AD_PERM**
  - `perm_en_o`=1; `round_o` steps 6..11 (pb, 6 rounds).
  - At round 11, if `block_o`=NB_AD-1: `domain_sep_o`=1, block←0, go to PT_WAIT.
  - At round 11 otherwise: block←block+1, go to AD_WAIT.
- **PT_WAIT**
  - `data_req_o`=1.
  - On block accept: `xor_data_o`=1 and `cipher_valid_o`=1.
  - If `block_o`=NB_PT-1: also `xor_key_begin_o`=1, round←0, go to FINAL.
  - Otherwise: round←6, go to PT_PERM.
- **PT_PERM**
  - Rounds 6..11 with `perm_en_o`=1.
  - At round 11: block←block+1, go to PT_WAIT.
- **FINAL**
  - Rounds 0..11 with `perm_en_o`=1.
  - At round 11: `xor_key_end_o`=1, go to DONE.
- **DONE**
  - `done_o`=1 for one cycle, then go to IDLE. Block←0 and round←0.
- Arithmetic:
  - `round_o` is 4 bits and never exceeds 11; it reloads to 0 or 6 on each phase entry.
  - `block_o` is 3 bits. For NB=8 it reaches 7 and is then reset, never incremented past 7; there is no wrap-around.

## Timing
- Reset (asynchronous, any state): state=IDLE, round=0, block=0. Every output is 0 while `resetb_i`=0 and in IDLE with `start_i`=0.
- Reset during a message aborts it. No `done_o` is produced. The next message needs a fresh `start_i`.
- With `data_valid_i` held at 1 and the `start_i` sampling cycle numbered 0:
  - INIT occupies cycles 1..12.
  - Each AD block and each non-last PT block costs 7 cycles (1 wait + 6 rounds).
  - The last PT block costs 1 cycle.
  - FINAL takes 12 cycles.
  - `done_o` is high in cycle 19+7·(NB_AD+NB_PT).
- Each wait cycle with `data_valid_i`=0 adds exactly 1 cycle of latency.
- `data_valid_i` is ignored outside AD_WAIT and PT_WAIT.
- `start_i` held high through DONE does not start a new message in the DONE cycle. It starts one in the following IDLE cycle, giving back-to-back messages with a 1-cycle IDLE gap.

## Test plan
- **Default parameters, `data_valid_i`=1:** `start_i` pulse at cycle 0 → `init_state_o`=1 at cycle 0; `xor_key_end_o` at 12; `domain_sep_o` at 19; `cipher_valid_o` at 20, 27, 34, 41; `xor_key_begin_o` at 41; `done_o` at 54.
- **Round sequence:** record `round_o` over the same run → INIT 0..11, each PERM phase 6..11, FINAL 0..11; `perm_en_o` high on exactly 12+6+18+12=48 cycles.
- **Back-pressure:** `data_valid_i`=0 for 3 cycles in the first PT_WAIT → `data_req_o` held high, `block_o`=0 held, no strobes, `done_o` delayed to 57.
- **NB_AD=0, NB_PT=1:** `domain_sep_o` and `xor_key_end_o` both at 12; `xor_data_o`, `cipher_valid_o` and `xor_key_begin_o` at 13; `done_o` at 26.
- **Reset mid-FINAL (cycle 45):** all outputs 0 immediately; `busy_o`=0; no `done_o`. A new `start_i` at 50 gives `done_o` at 104.
- **Limits NB_AD=8, NB_PT=8:** `block_o` reaches 7 in both phases and never wraps; `done_o` at 131; `start_i` held high gives the next `init_state_o` at 132.
